// File: rtl/zone_pixel_stats_if.sv
// ---------------------------------------------------------------------------
// zone_pixel_stats_if
// Pixel-stream and per-zone statistics bundle for zone_pixel_stats.
//   iDE       : data enable, high for each active pixel of a line
//   iY        : luma sample (DW bits), meaningful only while iDE=1
//   oZoneMax  : per-zone maximum of the last good line, zone z at [z*DW +: DW]
//   oZoneSum  : per-zone sum of the last good line, zone z at [z*SW +: SW]
//   oValid    : one-cycle pulse when oZoneMax/oZoneSum update
//   oLineErr  : one-cycle pulse when a line ends with the wrong pixel count
// master = pixel source / statistics consumer, slave = the statistics block.
// ---------------------------------------------------------------------------
interface zone_pixel_stats_if #(
    parameter int DW    = 8,
    parameter int NZONE = 24,
    parameter int SW    = 15
);
    logic                  iDE;
    logic [DW-1:0]         iY;
    logic [NZONE*DW-1:0]   oZoneMax;
    logic [NZONE*SW-1:0]   oZoneSum;
    logic                  oValid;
    logic                  oLineErr;

    modport master (
        output iDE, iY,
        input  oZoneMax, oZoneSum, oValid, oLineErr
    );

    modport slave (
        input  iDE, iY,
        output oZoneMax, oZoneSum, oValid, oLineErr
    );
endinterface

// File: rtl/zone_pixel_stats.sv
// ---------------------------------------------------------------------------
// zone_pixel_stats
// Splits each video line into NZONE horizontal zones of ZW pixels and gathers
// the per-zone luma maximum and sum for backlight control. Pixel position is
// self-counted from iDE. A line that ends with exactly NZONE*ZW pixels
// publishes its statistics and pulses oValid; any other length pulses
// oLineErr and leaves the published statistics untouched.
// Ports:
//   iODCK : pixel clock, rising edge
//   iRST  : synchronous active-high reset
//   bus   : zone_pixel_stats_if.slave (iDE, iY in; oZoneMax, oZoneSum,
//           oValid, oLineErr out)
// ---------------------------------------------------------------------------
module zone_pixel_stats #(
    parameter int DW    = 8,
    parameter int NZONE = 24,
    parameter int ZW    = 80
) (
    input  logic               iODCK,
    input  logic               iRST,
    zone_pixel_stats_if.slave  bus
);
    // ZW*(2^DW-1) < 2^(DW+clog2(ZW)), so the sums can never wrap.
    localparam int SW  = DW + $clog2(ZW);
    localparam int ZCW = $clog2(NZONE + 1);
    localparam int PCW = (ZW > 1) ? $clog2(ZW) : 1;

    logic [DW-1:0]        wMax [NZONE];
    logic [SW-1:0]        wSum [NZONE];
    logic [ZCW-1:0]       zc;
    logic [PCW-1:0]       pc;
    logic                 lineLong;
    logic                 deD;
    logic [NZONE*DW-1:0]  zoneMaxR;
    logic [NZONE*SW-1:0]  zoneSumR;
    logic                 validR;
    logic                 lineErrR;

    logic                 lineEnd;
    logic                 lineGood;

    // Falling edge of iDE as seen through the registered copy.
    assign lineEnd  = deD && !bus.iDE;
    assign lineGood = (zc == ZCW'(NZONE)) && (pc == '0) && !lineLong;

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            for (int z = 0; z < NZONE; z++) begin
                wMax[z] <= '0;
                wSum[z] <= '0;
            end
            zc       <= '0;
            pc       <= '0;
            lineLong <= 1'b0;
            deD      <= 1'b0;
            zoneMaxR <= '0;
            zoneSumR <= '0;
            validR   <= 1'b0;
            lineErrR <= 1'b0;
        end else begin
            deD      <= bus.iDE;
            validR   <= 1'b0;
            lineErrR <= 1'b0;

            if (lineEnd) begin
                if (lineGood) begin
                    for (int z = 0; z < NZONE; z++) begin
                        zoneMaxR[z*DW +: DW] <= wMax[z];
                        zoneSumR[z*SW +: SW] <= wSum[z];
                    end
                    validR <= 1'b1;
                end else begin
                    lineErrR <= 1'b1;
                end
                // Working state is cleared whatever the verdict, so the next
                // line always starts from zone 0 with empty accumulators.
                for (int z = 0; z < NZONE; z++) begin
                    wMax[z] <= '0;
                    wSum[z] <= '0;
                end
                zc       <= '0;
                pc       <= '0;
                lineLong <= 1'b0;
            end else if (bus.iDE) begin
                if (zc != ZCW'(NZONE)) begin
                    for (int z = 0; z < NZONE; z++) begin
                        if (zc == ZCW'(z)) begin
                            if (bus.iY > wMax[z]) begin
                                wMax[z] <= bus.iY;
                            end
                            wSum[z] <= wSum[z] + SW'(bus.iY);
                        end
                    end
                    if (pc == PCW'(ZW - 1)) begin
                        pc <= '0;
                        zc <= zc + 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end else begin
                    // Every zone is already full: the line is overlong.
                    lineLong <= 1'b1;
                end
            end
        end
    end

    assign bus.oZoneMax = zoneMaxR;
    assign bus.oZoneSum = zoneSumR;
    assign bus.oValid   = validR;
    assign bus.oLineErr = lineErrR;

endmodule

// File: tb/tb_zone_pixel_stats.sv
// ---------------------------------------------------------------------------
// tb_zone_pixel_stats
// Drives lines of pixels into zone_pixel_stats. For every line the bench
// keeps the whole line in a queue, decides from its length whether it is
// good, computes the per-zone max/sum from pixel index / ZW and pushes the
// expected event (kind, cycle, outputs) onto a scoreboard. A monitor pops
// and compares whenever oValid or oLineErr is seen.
// ---------------------------------------------------------------------------
module tb_zone_pixel_stats;
    localparam int DW    = 8;
    localparam int NZONE = 24;
    localparam int ZW    = 80;
    localparam int SW    = DW + $clog2(ZW);
    localparam int NPIX  = NZONE * ZW;

    typedef struct {
        bit                  isErr;
        int                  cyc;
        logic [NZONE*DW-1:0] mx;
        logic [NZONE*SW-1:0] sm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t                expQ [$];
    logic [NZONE*DW-1:0] lastMx;
    logic [NZONE*SW-1:0] lastSm;

    zone_pixel_stats_if #(.DW(DW), .NZONE(NZONE), .SW(SW)) bus ();

    zone_pixel_stats #(.DW(DW), .NZONE(NZONE), .ZW(ZW)) dut (
        .iODCK (clk),
        .iRST  (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [NZONE*SW-1:0] act,
                       input logic [NZONE*SW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    // Pixel patterns: 0 random, 1 ten times the zone index, 2 ramp in zone 0,
    // 3 full scale.
    function automatic int pixVal(input int mode, input int i);
        case (mode)
            1:       return (10 * (i / ZW)) & 255;
            2:       return (i < ZW) ? i : 0;
            3:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic sendLine(input int n, input int mode, input int gap);
        int   vals [$];
        int   v;
        int   mxA [NZONE];
        int   smA [NZONE];
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            v = pixVal(mode, i);
            bus.iDE = 1'b1;
            bus.iY  = DW'(v);
            vals.push_back(v);
        end
        @(posedge clk); #1;
        bus.iDE = 1'b0;
        bus.iY  = DW'($urandom);
        e.cyc = cyc + 1;
        if (vals.size() == NPIX) begin
            for (int z = 0; z < NZONE; z++) begin
                mxA[z] = 0;
                smA[z] = 0;
            end
            foreach (vals[i]) begin
                if (vals[i] > mxA[i / ZW]) mxA[i / ZW] = vals[i];
                smA[i / ZW] += vals[i];
            end
            for (int z = 0; z < NZONE; z++) begin
                e.mx[z*DW +: DW] = DW'(mxA[z]);
                e.sm[z*SW +: SW] = SW'(smA[z]);
            end
            e.isErr = 1'b0;
            lastMx  = e.mx;
            lastSm  = e.sm;
        end else begin
            e.isErr = 1'b1;
            e.mx    = lastMx;
            e.sm    = lastSm;
        end
        expQ.push_back(e);
        repeat (gap) @(posedge clk);
    endtask

    // n pixels, then one reset cycle that swallows pixel n. With deAfter=0
    // iDE drops as reset releases; with deAfter=1 the caller continues the
    // line straight away (sendLine releases reset on its first pixel).
    task automatic resetMid(input int n, input bit deAfter);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.iDE = 1'b1;
            bus.iY  = DW'($urandom);
        end
        @(posedge clk); #1;
        rst     = 1'b1;
        bus.iDE = 1'b1;
        bus.iY  = DW'($urandom);
        lastMx  = '0;
        lastSm  = '0;
        if (!deAfter) begin
            @(posedge clk); #1;
            rst     = 1'b0;
            bus.iDE = 1'b0;
            @(negedge clk);
            chk("rstMidMax", bus.oZoneMax, '0);
            chk("rstMidSum", bus.oZoneSum, '0);
            repeat (4) @(posedge clk);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (bus.oValid === 1'b1 && bus.oLineErr === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL bothFlags got oValid=1 oLineErr=1 want at most one");
        end
        if (bus.oValid === 1'b1 || bus.oLineErr === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpectedEvent got oValid=%0b oLineErr=%0b at cycle %0d want none",
                         bus.oValid, bus.oLineErr, cyc);
            end else begin
                e = expQ.pop_front();
                chk("evtKindErr", {{(NZONE*SW-1){1'b0}}, bus.oLineErr}, {{(NZONE*SW-1){1'b0}}, e.isErr});
                chk("evtCycle", NZONE*SW'(cyc), NZONE*SW'(e.cyc));
                chk("zoneMax", {{(NZONE*(SW-DW)){1'b0}}, bus.oZoneMax}, {{(NZONE*(SW-DW)){1'b0}}, e.mx});
                chk("zoneSum", bus.oZoneSum, e.sm);
            end
        end
    end

    initial begin
        lastMx  = '0;
        lastSm  = '0;
        rst     = 1'b1;
        bus.iDE = 1'b0;
        bus.iY  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstMax", bus.oZoneMax, '0);
        chk("rstSum", bus.oZoneSum, '0);
        chk("rstValid", bus.oValid, '0);
        chk("rstLineErr", bus.oLineErr, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        sendLine(NPIX, 1, 5);          // zone z holds 10*z
        sendLine(NPIX, 2, 3);          // ramp in zone 0
        sendLine(NPIX, 3, 3);          // all full scale
        sendLine(NPIX, 0, 0);          // random, back-to-back
        sendLine(NPIX, 0, 2);
        sendLine(1000, 1, 3);          // short line
        sendLine(NPIX, 1, 3);          // recovers cleanly
        sendLine(NPIX + 5, 0, 3);      // long line
        sendLine(1, 0, 3);             // one-pixel line
        sendLine(NPIX - 1, 0, 1);
        sendLine(NPIX + 1, 0, 1);

        resetMid(500, 1'b0);           // partial line discarded, no event
        sendLine(NPIX, 0, 3);
        resetMid(700, 1'b1);           // counting restarts at release
        sendLine(NPIX, 0, 3);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0:       sendLine(NPIX, 0, int'($urandom_range(0, 3)));
                1:       sendLine(NPIX - 1, 0, int'($urandom_range(0, 3)));
                2:       sendLine(NPIX + 1, 0, int'($urandom_range(0, 3)));
                default: sendLine(int'($urandom_range(1, 2000)), 0, int'($urandom_range(0, 3)));
            endcase
        end

        repeat (6) @(posedge clk);
        chk("pendingEvents", NZONE*SW'(expQ.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
